// File: rtl/pdfd_tap_ctrl.sv
// Tap controller for the PDFD decoder.
// Tap writes land in a shadow bank. A commit copies the shadow bank into the
// active bank that drives the decoder. After each swap the decoder pipeline
// holds symbols built from mixed taps, so the symbol stream is gated off for a
// fixed flush window. Commits that arrive during the flush are merged into one
// deferred swap.
module pdfd_tap_ctrl #(
    parameter int NUM_TAPS     = 14,
    parameter int FLUSH_CYCLES = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_cfgValid,
    output logic              io_cfgReady,
    input  logic [3:0]        io_cfgAddr,
    input  logic signed [7:0] io_cfgData,
    input  logic              io_commit,
    output logic signed [7:0] io_taps_0,
    output logic signed [7:0] io_taps_1,
    output logic signed [7:0] io_taps_2,
    output logic signed [7:0] io_taps_3,
    output logic signed [7:0] io_taps_4,
    output logic signed [7:0] io_taps_5,
    output logic signed [7:0] io_taps_6,
    output logic signed [7:0] io_taps_7,
    output logic signed [7:0] io_taps_8,
    output logic signed [7:0] io_taps_9,
    output logic signed [7:0] io_taps_10,
    output logic signed [7:0] io_taps_11,
    output logic signed [7:0] io_taps_12,
    output logic signed [7:0] io_taps_13,
    input  logic [11:0]       io_decSymbols,
    input  logic              io_decValid,
    output logic [11:0]       io_rxSymbols,
    output logic              io_rxValid,
    output logic              io_busy,
    output logic              io_cfgErr,
    output logic [7:0]        io_commitCnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_PEND  = 2'd2;

    localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYCLES);
    localparam logic [4:0] TAP_LIMIT  = 5'(NUM_TAPS);

    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [7:0]        fcnt_r;
    logic [7:0]        fcnt_next_s;
    logic              pend_r;
    logic              pend_next_s;
    logic              swap_s;
    logic              wr_ok_s;
    logic              wr_bad_s;
    logic              busy_r;
    logic              cfg_err_r;
    logic              cfg_ready_r;
    logic [7:0]        commit_cnt_r;
    logic signed [7:0] shadow_r      [14];
    logic signed [7:0] shadow_next_s [14];
    logic signed [7:0] active_r      [14];

    // Classify a write request as an in-range tap update or a bad address.
    always_comb begin
        wr_ok_s  = 1'b0;
        wr_bad_s = 1'b0;
        if (io_cfgValid && ({1'b0, io_cfgAddr} < TAP_LIMIT)) begin
            wr_ok_s = 1'b1;
        end else if (io_cfgValid) begin
            wr_bad_s = 1'b1;
        end else begin
            wr_ok_s  = 1'b0;
            wr_bad_s = 1'b0;
        end
    end

    // Shadow bank as it will be after this edge; a swap copies this view,
    // so a write in the swap cycle wins over the old shadow value.
    always_comb begin
        shadow_next_s = shadow_r;
        if (wr_ok_s) begin
            shadow_next_s[io_cfgAddr] = io_cfgData;
        end else begin
            shadow_next_s = shadow_r;
        end
    end

    // Swap/flush sequencing: IDLE swaps on commit, FLUSH counts down and
    // remembers commits, PEND performs the deferred swap.
    always_comb begin
        state_next_s = state_r;
        fcnt_next_s  = fcnt_r;
        pend_next_s  = pend_r;
        swap_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pend_next_s = 1'b0;
                if (io_commit) begin
                    swap_s       = 1'b1;
                    state_next_s = ST_FLUSH;
                    fcnt_next_s  = FLUSH_INIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                fcnt_next_s = fcnt_r - 8'd1;
                if (io_commit) begin
                    pend_next_s = 1'b1;
                end else begin
                    pend_next_s = pend_r;
                end
                if (fcnt_r <= 8'd1) begin
                    if (pend_r || io_commit) begin
                        state_next_s = ST_PEND;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            ST_PEND: begin
                swap_s       = 1'b1;
                pend_next_s  = 1'b0;
                state_next_s = ST_FLUSH;
                fcnt_next_s  = FLUSH_INIT;
            end
            default: begin
                pend_next_s  = 1'b0;
                state_next_s = ST_FLUSH;
                fcnt_next_s  = FLUSH_INIT;
            end
        endcase
    end

    // Control registers; reset starts a flush so the pipeline is drained.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_FLUSH;
            fcnt_r       <= FLUSH_INIT;
            pend_r       <= 1'b0;
            busy_r       <= 1'b1;
            cfg_ready_r  <= 1'b1;
            cfg_err_r    <= 1'b0;
            commit_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_next_s;
            fcnt_r      <= fcnt_next_s;
            pend_r      <= pend_next_s;
            busy_r      <= (state_next_s != ST_IDLE);
            cfg_ready_r <= 1'b1;
            if (wr_bad_s) begin
                cfg_err_r <= 1'b1;
            end
            if (swap_s) begin
                commit_cnt_r <= commit_cnt_r + 8'd1;
            end
        end
    end

    // Shadow and active tap banks; active only changes on a swap edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 14; i++) begin
                shadow_r[i] <= 8'sd0;
                active_r[i] <= 8'sd0;
            end
        end else begin
            shadow_r <= shadow_next_s;
            if (swap_s) begin
                active_r <= shadow_next_s;
            end
        end
    end

    assign io_rxValid   = io_decValid & (state_r == ST_IDLE);
    assign io_rxSymbols = io_rxValid ? io_decSymbols : 12'd0;
    assign io_busy      = busy_r;
    assign io_cfgErr    = cfg_err_r;
    assign io_cfgReady  = cfg_ready_r;
    assign io_commitCnt = commit_cnt_r;

    assign io_taps_0  = active_r[0];
    assign io_taps_1  = active_r[1];
    assign io_taps_2  = active_r[2];
    assign io_taps_3  = active_r[3];
    assign io_taps_4  = active_r[4];
    assign io_taps_5  = active_r[5];
    assign io_taps_6  = active_r[6];
    assign io_taps_7  = active_r[7];
    assign io_taps_8  = active_r[8];
    assign io_taps_9  = active_r[9];
    assign io_taps_10 = active_r[10];
    assign io_taps_11 = active_r[11];
    assign io_taps_12 = active_r[12];
    assign io_taps_13 = active_r[13];

endmodule

// File: doc/pdfd_tap_ctrl.md
PDFD_TAP_CTRL -- requirements
Module: pdfd_tap_ctrl

Parameters
REQ-001 SHALL have parameter NUM_TAPS, default 14, the number of decoder taps.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 17, the decoder pipeline depth to flush after a tap swap (legal range 1..255).

Interface
REQ-003 SHALL have port clock, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port io_cfgValid, input, 1 bit: shadow tap write request.
REQ-006 SHALL have port io_cfgReady, output, 1 bit: shadow write accepted when high together with io_cfgValid.
REQ-007 SHALL have port io_cfgAddr, input, 4 bits: tap index.
REQ-008 SHALL have port io_cfgData, input, 8 bits signed: tap value.
REQ-009 SHALL have port io_commit, input, 1 bit: single-cycle request to swap shadow taps into the active taps.
REQ-010 SHALL have ports io_taps_0..io_taps_13, output, 8 bits signed each: active taps driven to the decoder.
REQ-011 SHALL have ports io_decSymbols, input, 12 bits, and io_decValid, input, 1 bit: decoder symbol output and its valid.
REQ-012 SHALL have ports io_rxSymbols, output, 12 bits, and io_rxValid, output, 1 bit: gated symbol stream.
REQ-013 SHALL have port io_busy, output, 1 bit: high in FLUSH or PEND.
REQ-014 SHALL have port io_cfgErr, output, 1 bit: sticky bad-address flag.
REQ-015 SHALL have port io_commitCnt, output, 8 bits: count of completed swaps, wraps 255 to 0.

Function
REQ-016 SHALL implement FSM states IDLE, FLUSH and PEND, with a flush counter fcnt 8 bits wide.
REQ-017 SHALL hold io_cfgReady at 1 in every state, so shadow writes are always accepted.
REQ-018 SHALL, on an accepted write with io_cfgAddr < NUM_TAPS, set shadow[io_cfgAddr] to io_cfgData at the next edge.
REQ-019 SHALL drop an accepted write with io_cfgAddr >= NUM_TAPS, leave the shadow unchanged, and set io_cfgErr, which only reset clears.
REQ-020 SHALL, in IDLE with io_commit=1, at the next edge copy all shadow taps to active, go to FLUSH, load fcnt=FLUSH_CYCLES, and increment io_commitCnt.
REQ-021 SHALL, when a valid write and io_commit occur in the same IDLE cycle, give the written address the new io_cfgData in the active taps (write takes precedence over swap).
REQ-022 SHALL, in FLUSH, decrement fcnt each cycle; at fcnt==1 go to IDLE, or to PEND if a commit is pending; FLUSH lasts exactly FLUSH_CYCLES cycles.
REQ-023 SHALL, on io_commit during FLUSH, set a pending flag; extra commits during FLUSH merge into a single pending flag.
REQ-024 SHALL, in PEND, perform the swap at the next edge exactly as REQ-020 (using the shadow as of that edge, including any same-cycle write), clear the pending flag, and return to FLUSH.
REQ-025 SHALL ignore io_commit in PEND, because the swap already occurring absorbs it.
REQ-026 SHALL drive io_rxValid = io_decValid only in IDLE, and 0 otherwise.
REQ-027 SHALL drive io_rxSymbols = io_decSymbols when io_rxValid=1, and 0 otherwise, combinationally with zero latency.
REQ-028 SHALL change the active taps only on swap edges, never by a write alone.
REQ-029 SHALL have io_busy and all outputs other than io_rxValid/io_rxSymbols come from registers.

Reset
REQ-030 SHALL, on asynchronous reset assertion, immediately clear shadow and active taps to 0, io_cfgErr to 0, io_commitCnt to 0 and the pending flag to 0.
REQ-031 SHALL, on reset assertion, set state to FLUSH with fcnt=FLUSH_CYCLES, so io_rxValid=0 and io_busy=1.
REQ-032 SHALL, after reset deasserts, keep io_rxValid at 0 for exactly FLUSH_CYCLES (default 17) cycles before entering IDLE.
REQ-033 SHALL, when reset is asserted during FLUSH or PEND, discard the pending commit and restart the flush per REQ-031.

Verification
REQ-034 SHALL cover: reset, then io_decValid=1 constant -> io_rxValid=0 for cycles 1..17 after deassert and 1 from cycle 18; all io_taps=0.
REQ-035 SHALL cover: write addr0..13 with values 10..23, then commit -> io_taps_k=10+k on the edge after commit, io_rxValid low for 17 cycles, io_commitCnt=1.
REQ-036 SHALL cover: write addr 5 = -7 and commit in the same IDLE cycle -> io_taps_5=-7 after the swap edge.
REQ-037 SHALL cover: commit at flush cycle 3, write addr2=33 at cycle 10, commit again at cycle 12 -> one PEND swap with io_taps_2=33, one more 17-cycle flush, io_commitCnt=2 total.
REQ-038 SHALL cover: write addr 14 = 55 -> io_cfgErr=1 stays set, shadow unchanged, active taps unchanged after a later commit except for legitimately written taps.
REQ-039 SHALL cover: 256 commits spaced beyond the flush window -> io_commitCnt wraps to 0; reset mid-flush with a commit pending -> no swap occurs and io_commitCnt=0.
